// File: rtl/subleq_prog_mem.sv
// Clocked program memory for the Subleq core: registered fetch port plus a
// byte-stream loader that packs host bytes LSB-first into instruction words.
module subleq_prog_mem #(
  parameter int P_ADDR = 8,
  parameter int P_DATA = 27,
  parameter int P_MEM  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [P_ADDR-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [P_DATA-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic              load_done,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_byte,
  output logic              load_busy,
  output logic [P_ADDR:0]   load_count,
  output logic              load_ovf
);

  localparam int NB  = (P_DATA + 7) / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int MAW = (P_MEM > 1) ? $clog2(P_MEM) : 1;
  localparam logic [P_ADDR:0] MEM_WORDS = (P_ADDR+1)'(P_MEM);

  typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
  logic [P_DATA-1:0] asm_q, asm_d;
  logic [P_ADDR:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [P_DATA-1:0] data_q, data_d;

  logic [P_DATA-1:0] mem_q [P_MEM];

  logic              byte_acc_s;
  logic              complete_s;
  logic              do_word_s;
  logic              wr_en_s;
  logic [P_DATA-1:0] ins_s;
  logic [P_DATA-1:0] wr_word_s;
  logic              accept_s;
  logic              addr_oor_s;

  assign fetch_gnt   = fetch_req & (state_q == S_IDLE);
  assign ld_ready    = (state_q == S_LOAD);
  assign load_busy   = (state_q == S_LOAD);
  assign load_count  = count_q;
  assign load_ovf    = ovf_q;
  assign fetch_valid = valid_q;
  assign fetch_err   = err_q;
  assign fetch_data  = data_q;

  // Loader FSM: byte assembly, word commit, flush and overflow tracking
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    wr_en_s    = 1'b0;
    do_word_s  = 1'b0;
    byte_acc_s = ld_valid & (state_q == S_LOAD);
    // Shifting in P_DATA width drops byte bits that land above the word.
    ins_s      = P_DATA'(ld_byte) << {byte_cnt_q, 3'b000};
    wr_word_s  = byte_acc_s ? (asm_q | ins_s) : asm_q;
    complete_s = byte_acc_s && (byte_cnt_q == BCW'(NB - 1));
    if (load_start) begin
      state_d    = S_LOAD;
      byte_cnt_d = '0;
      asm_d      = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
    end else if (state_q == S_LOAD) begin
      do_word_s = complete_s | (load_done & (byte_acc_s | (byte_cnt_q != '0)));
      if (complete_s || load_done) begin
        byte_cnt_d = '0;
        asm_d      = '0;
      end else if (byte_acc_s) begin
        byte_cnt_d = byte_cnt_q + BCW'(1);
        asm_d      = wr_word_s;
      end else begin
        asm_d = asm_q;
      end
      if (do_word_s) begin
        if (count_q < MEM_WORDS) begin
          wr_en_s = 1'b1;
          count_d = count_q + (P_ADDR+1)'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        ovf_d = ovf_q;
      end
      if (load_done) begin
        state_d = S_IDLE;
      end else begin
        state_d = S_LOAD;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // Fetch path: accepted only in IDLE, result appears one cycle later
  always_comb begin
    accept_s   = fetch_req & (state_q == S_IDLE);
    addr_oor_s = ({1'b0, fetch_addr} >= MEM_WORDS);
    valid_d    = accept_s;
    err_d      = accept_s & addr_oor_s;
    data_d     = data_q;
    if (accept_s) begin
      if (addr_oor_s) begin
        data_d = '0;
      end else begin
        data_d = mem_q[fetch_addr[MAW-1:0]];
      end
    end else begin
      data_d = data_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      data_q     <= data_d;
    end
  end

  // Word storage; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[count_q[MAW-1:0]] <= wr_word_s;
    end
  end

endmodule

// File: tb/tb_subleq_prog_mem.sv
// Randomized self-checking bench for subleq_prog_mem against a byte-queue
// reference model of the loader and an array model of the memory.
module tb_subleq_prog_mem;
  localparam int P_ADDR = 8;
  localparam int P_DATA = 27;
  localparam int P_MEM  = 16;
  localparam int NB     = (P_DATA + 7) / 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fetch_req = 1'b0;
  logic [P_ADDR-1:0] fetch_addr = '0;
  logic              fetch_gnt;
  logic              fetch_valid;
  logic [P_DATA-1:0] fetch_data;
  logic              fetch_err;
  logic              load_start = 1'b0;
  logic              load_done = 1'b0;
  logic              ld_valid = 1'b0;
  logic              ld_ready;
  logic [7:0]        ld_byte = 8'h00;
  logic              load_busy;
  logic [P_ADDR:0]   load_count;
  logic              load_ovf;

  subleq_prog_mem #(.P_ADDR(P_ADDR), .P_DATA(P_DATA), .P_MEM(P_MEM)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_err(fetch_err),
    .load_start(load_start), .load_done(load_done), .ld_valid(ld_valid),
    .ld_ready(ld_ready), .ld_byte(ld_byte), .load_busy(load_busy),
    .load_count(load_count), .load_ovf(load_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [P_DATA-1:0] m_mem [P_MEM];
  bit                m_wr  [P_MEM];
  logic [7:0]        m_q[$];
  int                m_cnt = 0;
  bit                m_ovf = 1'b0;
  logic [P_DATA-1:0] last_data = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a word is the queued bytes, little-endian, truncated.
  task automatic m_commit();
    logic [31:0] w;
    w = 32'h0;
    foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
    if (m_cnt < P_MEM) begin
      m_mem[m_cnt] = w[P_DATA-1:0];
      m_wr[m_cnt]  = 1'b1;
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
    m_q.delete();
  endtask

  task automatic do_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit done);
    ld_valid  = 1'b1;
    ld_byte   = b;
    load_done = done;
    tick();
    ld_valid  = 1'b0;
    load_done = 1'b0;
    m_q.push_back(b);
    if (m_q.size() == NB) m_commit();
    if (done && m_q.size() > 0) m_commit();
  endtask

  task automatic do_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    if (m_q.size() > 0) m_commit();
  endtask

  task automatic check_load(input string tag);
    check_eq({tag, ".count"}, 64'(load_count), 64'(m_cnt));
    check_eq({tag, ".ovf"},   64'(load_ovf),   64'(m_ovf));
    check_eq({tag, ".busy"},  64'(load_busy),  64'(0));
  endtask

  task automatic fetch_burst(input string tag, input int a[$]);
    logic [P_DATA-1:0] exp_d;
    bit                exp_e;
    for (int i = 0; i < a.size(); i++) begin
      fetch_req  = 1'b1;
      fetch_addr = P_ADDR'(a[i]);
      #1;
      check_eq({tag, ".gnt"}, 64'(fetch_gnt), 64'(1));
      tick();
      exp_e = (a[i] >= P_MEM);
      exp_d = exp_e ? '0 : m_mem[a[i]];
      check_eq({tag, ".valid"}, 64'(fetch_valid), 64'(1));
      check_eq({tag, ".err"},   64'(fetch_err),   64'(exp_e));
      check_eq({tag, ".data"},  64'(fetch_data),  64'(exp_d));
      last_data = exp_d;
    end
    fetch_req = 1'b0;
    tick();
    check_eq({tag, ".idle_valid"}, 64'(fetch_valid), 64'(0));
    check_eq({tag, ".idle_err"},   64'(fetch_err),   64'(0));
    check_eq({tag, ".hold_data"},  64'(fetch_data),  64'(last_data));
  endtask

  // Asserted between clock edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq({tag, ".valid"}, 64'(fetch_valid), 64'(0));
    check_eq({tag, ".data"},  64'(fetch_data),  64'(0));
    check_eq({tag, ".err"},   64'(fetch_err),   64'(0));
    check_eq({tag, ".count"}, 64'(load_count),  64'(0));
    check_eq({tag, ".ovf"},   64'(load_ovf),    64'(0));
    check_eq({tag, ".ready"}, 64'(ld_ready),    64'(0));
    check_eq({tag, ".busy"},  64'(load_busy),   64'(0));
    m_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    last_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int aq[$];
    int n;
    int a;
    foreach (m_wr[i]) m_wr[i] = 1'b0;

    // Power-on reset
    #1;
    check_eq("por.valid", 64'(fetch_valid), 64'(0));
    check_eq("por.count", 64'(load_count), 64'(0));
    check_eq("por.ready", 64'(ld_ready), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed load: top bit of the fourth byte falls outside 27 bits
    do_start();
    check_eq("load.ready", 64'(ld_ready), 64'(1));
    send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h80, 1'b0);
    send(8'hEF, 1'b0); send(8'hBE, 1'b0); send(8'hAD, 1'b0); send(8'h0B, 1'b0);
    do_done();
    check_load("load2");
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    check_eq("b2b.valid0", 64'(fetch_valid), 64'(1));
    check_eq("b2b.data0",  64'(fetch_data),  64'(27'h0000001));
    fetch_addr = 8'd1;
    tick();
    check_eq("b2b.valid1", 64'(fetch_valid), 64'(1));
    check_eq("b2b.data1",  64'(fetch_data),  64'(27'h3ADBEEF));
    fetch_req = 1'b0;
    tick();
    check_eq("b2b.end", 64'(fetch_valid), 64'(0));
    last_data = 27'h3ADBEEF;

    // Partial flush pads the upper bytes with zero
    do_start();
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    do_done();
    check_load("flush");
    fetch_req = 1'b1; fetch_addr = 8'd0;
    tick();
    fetch_req = 1'b0;
    check_eq("flush.data", 64'(fetch_data), 64'(27'h0003412));
    last_data = 27'h0003412;

    // Byte completing a word together with load_done gives a single write
    do_start();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'h05, 1'b1);
    check_load("done_full");
    send(8'h77, 1'b0);
    check_eq("idle_byte.count", 64'(load_count), 64'(m_cnt));

    // Fetch stalled during a load
    do_start();
    fetch_req = 1'b1; fetch_addr = 8'd0;
    #1;
    check_eq("stall.gnt", 64'(fetch_gnt), 64'(0));
    tick();
    check_eq("stall.valid", 64'(fetch_valid), 64'(0));
    fetch_req = 1'b0;
    send(8'h5A, 1'b1);
    check_load("stall");

    // Out-of-range fetches
    aq.delete(); aq.push_back(P_MEM); aq.push_back(0); aq.push_back(255);
    fetch_burst("range", aq);

    // Overflow: two words beyond capacity
    do_start();
    for (int i = 0; i < (P_MEM + 2) * NB; i++) send(8'($urandom), 1'b0);
    do_done();
    check_load("ovf");
    aq.delete();
    for (int i = 0; i < P_MEM; i++) aq.push_back(i);
    fetch_burst("ovf_rd", aq);
    do_start();
    check_eq("ovf_clr.ovf",   64'(load_ovf),   64'(0));
    check_eq("ovf_clr.count", 64'(load_count), 64'(0));
    // Restart discards the partial word
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    do_start();
    send(8'h33, 1'b0);
    do_done();
    check_load("restart");

    // Randomized loads followed by randomized fetches
    for (int r = 0; r < 8; r++) begin
      do_start();
      n = $urandom_range(1, 4 * (P_MEM + 3));
      for (int i = 0; i < n - 1; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(8'($urandom), 1'b0);
      end
      if ($urandom_range(0, 1) == 1) begin
        send(8'($urandom), 1'b1);
      end else begin
        send(8'($urandom), 1'b0);
        do_done();
      end
      check_load("rnd");
      aq.delete();
      for (int i = 0; i < 6; i++) begin
        a = $urandom_range(0, P_MEM + 3);
        if (a < P_MEM && !m_wr[a]) a = P_MEM + 100;
        aq.push_back(a);
      end
      fetch_burst("rnd_rd", aq);
    end

    // Reset mid-load keeps words already written
    do_start();
    for (int i = 0; i < 2 * NB + 1; i++) send(8'($urandom), 1'b0);
    async_reset("midload");
    aq.delete(); aq.push_back(0); aq.push_back(1);
    fetch_burst("post_rst", aq);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
